// File: rtl/r4_pkg.sv
// r4_pkg: shared types for the R4 multi-cycle control slice.
//   state_t  - control FSM states (3-bit encoding, value 7 unused)
//   pc_src_t - PC source select presented at commit
//   ctrl_t   - decoder control bits captured in DECODE
//   pcSel    - commit-time PC source priority (jump over taken branch)
package r4_pkg;

    localparam int unsigned ALUOP_W = 4;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        DECODE  = 3'd2,
        EXECUTE = 3'd3,
        MEM     = 3'd4,
        WB      = 3'd5,
        TRAP    = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        PC_PLUS4  = 2'b00,
        PC_BRANCH = 2'b01,
        PC_JUMP   = 2'b10
    } pc_src_t;

    typedef struct packed {
        logic               memWrite;
        logic               regWrite;
        logic               aluSrc;
        logic [ALUOP_W-1:0] aluOp;
        logic               memToReg;
        logic               branch;
        logic               jump;
    } ctrl_t;

    function automatic pc_src_t pcSel(input logic jump, input logic taken);
        if (jump) begin
            return PC_JUMP;
        end else if (taken) begin
            return PC_BRANCH;
        end
        return PC_PLUS4;
    endfunction

endpackage

// File: rtl/r4_wait_timer.sv
// r4_wait_timer: counts consecutive cycles spent waiting for a memory ready.
//   clk, reset_n - clock / asynchronous active-low reset
//   clear        - zero the count (asserted on every FSM state change)
//   count        - a wait cycle without ready is in progress
//   expired      - current cycle is the last allowed wait cycle; if ready is
//                  still low now, the waiter gives up. Never set when TIMEOUT=0.
module r4_wait_timer #(
    parameter int unsigned TIMEOUT = 0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic count,
    output logic expired
);

    localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    logic [CW-1:0] cnt;

    // cnt holds the number of wait cycles already completed, so the
    // TIMEOUT-th consecutive miss is the one seen while cnt == TIMEOUT-1.
    assign expired = (TIMEOUT != 0) && (cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (count && (TIMEOUT != 0) && !expired) begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/r4_multicycle_ctrl.sv
// r4_multicycle_ctrl: multi-cycle control FSM of the R4 RV32I core.
// Sequences FETCH/DECODE/EXECUTE/MEM/WB around a shared ALU, register file
// and req/ready instruction and data memories.
//   Inputs : clk, reset_n (async active-low), decoder controls (memWrite,
//            regWrite, aluSrc, aluOp, memToReg, branch, jump), ALU zero,
//            imem_ready, dmem_ready.
//   Outputs: imem_req, ir_we, dmem_req, dmem_we, rf_we, rf_wsel, alu_src_o,
//            alu_op_o, pc_we, pc_src, state_o (debug), instret, error.
// All strobes are decoded combinationally from the state and the control
// bits captured in DECODE; pc_we marks the commit cycle of an instruction.
module r4_multicycle_ctrl
    import r4_pkg::*;
#(
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned TIMEOUT = 0
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               memWrite,
    input  logic               regWrite,
    input  logic               aluSrc,
    input  logic [ALUOP_W-1:0] aluOp,
    input  logic               memToReg,
    input  logic               branch,
    input  logic               jump,
    input  logic               zero,
    input  logic               imem_ready,
    input  logic               dmem_ready,
    output logic               imem_req,
    output logic               ir_we,
    output logic               dmem_req,
    output logic               dmem_we,
    output logic               rf_we,
    output logic               rf_wsel,
    output logic               alu_src_o,
    output logic [ALUOP_W-1:0] alu_op_o,
    output logic               pc_we,
    output logic [1:0]         pc_src,
    output logic [2:0]         state_o,
    output logic [CNT_W-1:0]   instret,
    output logic               error
);

    state_t  state;
    state_t  nextState;
    ctrl_t   ctrlQ;
    logic    takenQ;
    logic    takenNow;
    logic    commit;
    pc_src_t pcSrcSel;
    logic    waitCount;
    logic    waitExpired;

    r4_wait_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_waitTimer (
        .clk    (clk),
        .reset_n(reset_n),
        .clear  (nextState != state),
        .count  (waitCount),
        .expired(waitExpired)
    );

    assign waitCount = ((state == FETCH) && !imem_ready) ||
                       ((state == MEM)   && !dmem_ready);

    // A plain branch commits in EXECUTE itself, so it must see zero live;
    // instructions committing later use the value sampled in EXECUTE.
    assign takenNow = (state == EXECUTE) ? (ctrlQ.branch & zero) : takenQ;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrlQ  <= '0;
            takenQ <= 1'b0;
        end else begin
            if (state == DECODE) begin
                ctrlQ.memWrite <= memWrite;
                ctrlQ.regWrite <= regWrite;
                ctrlQ.aluSrc   <= aluSrc;
                ctrlQ.aluOp    <= aluOp;
                ctrlQ.memToReg <= memToReg;
                ctrlQ.branch   <= branch;
                ctrlQ.jump     <= jump;
            end
            if (state == EXECUTE) begin
                takenQ <= ctrlQ.branch & zero;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            instret <= '0;
        end else if (commit) begin
            instret <= instret + CNT_W'(1);
        end
    end

    always_comb begin
        nextState = state;
        imem_req  = 1'b0;
        ir_we     = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        rf_we     = 1'b0;
        rf_wsel   = 1'b0;
        commit    = 1'b0;
        case (state)
            IDLE: begin
                nextState = FETCH;
            end
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_we     = 1'b1;
                    nextState = DECODE;
                end else if (waitExpired) begin
                    nextState = TRAP;
                end
            end
            DECODE: begin
                nextState = EXECUTE;
            end
            EXECUTE: begin
                if (ctrlQ.memWrite || ctrlQ.memToReg) begin
                    nextState = MEM;
                end else if (ctrlQ.regWrite) begin
                    nextState = WB;
                end else begin
                    commit    = 1'b1;
                    nextState = FETCH;
                end
            end
            MEM: begin
                dmem_req = 1'b1;
                dmem_we  = ctrlQ.memWrite;
                if (dmem_ready) begin
                    if (ctrlQ.memToReg) begin
                        nextState = WB;
                    end else begin
                        commit    = 1'b1;
                        nextState = FETCH;
                    end
                end else if (waitExpired) begin
                    nextState = TRAP;
                end
            end
            WB: begin
                rf_we     = 1'b1;
                rf_wsel   = ctrlQ.memToReg;
                commit    = 1'b1;
                nextState = FETCH;
            end
            TRAP: begin
                nextState = TRAP;
            end
            default: begin
                nextState = TRAP;
            end
        endcase
    end

    always_comb begin
        pcSrcSel = PC_PLUS4;
        if (commit) begin
            pcSrcSel = pcSel(ctrlQ.jump, takenNow);
        end
    end

    assign pc_we     = commit;
    assign pc_src    = pcSrcSel;
    assign alu_src_o = ctrlQ.aluSrc;
    assign alu_op_o  = ctrlQ.aluOp;
    assign state_o   = state;
    assign error     = (state == TRAP);

endmodule
